adc_blk_sched: RTL and testbench

- Buffers the 3-bit ADC samples from the 2-to-3-bit sign/magnitude converter into a two-bank ping-pong block buffer.
- Time-multiplexes each completed block to every correlator channel that requested it, using round-robin order, over one shared sample stream.
- Sits between the ADC conversion stage and the shared correlator datapath in the GPS engine.

---
 rtl/adc_blk_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_blk_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_blk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : adc_blk_sched
//  Purpose  : Collects 3-bit sign/magnitude ADC samples into a two-bank
//             ping-pong block buffer and replays every completed block to
//             each correlator channel that requested it, one channel at a
//             time in round-robin order, over a single shared stream.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        sample clock, rising edge
//    reset      asynchronous active-high reset
//    smp_valid  converted sample present this cycle
//    smp_data   converted sample (001/011/101/111)
//    ch_req     per-channel request level for the next block
//    out_ready  correlator accepts the current beat
//    out_valid  stream beat valid
//    out_data   buffered sample
//    out_ch     channel being served
//    out_first  first beat of a block replay
//    out_last   last beat of a block replay
//    busy       replay engine not idle
//    ovf_flag   sticky: a sample was dropped because both banks were full
//    ovf_clr    clears ovf_flag (and ovf_count when present)
//    ovf_count  dropped-sample count, saturating
//  Build option
//    SCHED_OVF_CNT_EN  when defined, ovf_count is a live saturating counter;
//                      otherwise it is tied to zero and no counter is built.
// ============================================================================
module adc_blk_sched #(
  parameter int NUM_CH  = 4,
  parameter int BLK_LEN = 16,
  parameter int CH_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_valid,
  input  logic [2:0]        smp_data,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2:0]        out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic [15:0]       ovf_count
);

  localparam int               IDX_W    = $clog2(BLK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t state, state_n;

  logic [2:0]        mem [2][BLK_LEN];
  logic [1:0]        full;
  logic              wr_bank, rd_bank;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [CH_W-1:0]   rr_ptr, cur_ch, arb_ch;
  logic [NUM_CH-1:0] pend, pend_rem, cur_mask;
  logic [CH_W:0]     sum;
  logic              found;

  logic wr_accept, drop, wr_done;
  logic take_req, free_rd, start_arb, advance, ch_done;

  // Fullness is judged on registered state only, so a bank released on the
  // same edge cannot yet accept the sample arriving on that edge.
  assign wr_accept = smp_valid & ~full[wr_bank];
  assign drop      = smp_valid &  full[wr_bank];
  assign wr_done   = wr_accept & (wr_idx == LAST_IDX);

  assign cur_mask  = NUM_CH'(1) << cur_ch;
  assign pend_rem  = pend & ~cur_mask;
  assign busy      = (state != S_IDLE);

  // Round-robin pick: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    arb_ch = rr_ptr;
    found  = 1'b0;
    sum    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!found && pend[sum[CH_W-1:0]]) begin
        arb_ch = sum[CH_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    take_req  = 1'b0;
    free_rd   = 1'b0;
    start_arb = 1'b0;
    advance   = 1'b0;
    ch_done   = 1'b0;
    out_valid = 1'b0;
    out_data  = 3'd0;
    out_ch    = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          if (|ch_req) begin
            take_req = 1'b1;
            state_n  = S_ARB;
          end else begin
            // Nobody wants this block: release it silently.
            free_rd = 1'b1;
          end
        end
      end
      S_ARB: begin
        start_arb = 1'b1;
        state_n   = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = mem[rd_bank][rd_idx];
        out_ch    = cur_ch;
        out_first = (rd_idx == '0);
        out_last  = (rd_idx == LAST_IDX);
        if (out_ready) begin
          advance = 1'b1;
          if (rd_idx == LAST_IDX) begin
            ch_done = 1'b1;
            if (pend_rem == '0) begin
              free_rd = 1'b1;
              state_n = S_IDLE;
            end else begin
              state_n = S_ARB;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Sample storage carries no reset; contents are only read after a write.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_bank][wr_idx] <= smp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      rr_ptr   <= '0;
      cur_ch   <= '0;
      pend     <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      // A completing write and a read release always target opposite banks.
      if (wr_done) full[wr_bank] <= 1'b1;
      if (free_rd) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (take_req) pend <= ch_req;
      if (start_arb) begin
        cur_ch <= arb_ch;
        rd_idx <= '0;
      end else if (advance) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
      if (ch_done) begin
        pend   <= pend_rem;
        rr_ptr <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
      end
      // Set has priority over clear.
      if (drop)         ovf_flag <= 1'b1;
      else if (ovf_clr) ovf_flag <= 1'b0;
    end
  end

`ifdef SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= 16'd0;
    end else if (ovf_clr) begin
      ovf_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && ovf_cnt != 16'hFFFF) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_blk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_blk_sched
//  Purpose  : Self-checking bench for adc_blk_sched. A transaction-level
//             model (queue of full blocks plus a precomputed replay schedule)
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_blk_sched;
  localparam int NUM_CH  = 4;
  localparam int BLK_LEN = 16;
  localparam int CH_W    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              smp_valid = 1'b0;
  logic [2:0]        smp_data = 3'd0;
  logic [NUM_CH-1:0] ch_req = '0;
  logic              out_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              out_valid, out_first, out_last, busy, ovf_flag;
  logic [2:0]        out_data;
  logic [CH_W-1:0]   out_ch;
  logic [15:0]       ovf_count;

  adc_blk_sched #(.NUM_CH(NUM_CH), .BLK_LEN(BLK_LEN), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .ch_req(ch_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_first(out_first),
    .out_last(out_last), .busy(busy), .ovf_flag(ovf_flag),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  typedef struct { bit gap; int ch; logic [2:0] data; bit first; bit last; } slot_t;
  slot_t                  sched[$];
  logic [3*BLK_LEN-1:0]   full_q[$];
  logic [3*BLK_LEN-1:0]   m_fill, m_blk;
  int                     m_fillcnt, m_rr, m_nfull, m_c;
  bit                     m_drop, m_freed, m_flag;
  slot_t                  m_head, m_s;
`ifdef SCHED_OVF_CNT_EN
  int                     m_cnt;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sched.delete(); full_q.delete();
      m_fill = '0; m_fillcnt = 0; m_rr = 0; m_flag = 0;
`ifdef SCHED_OVF_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      m_nfull = full_q.size();
      m_drop  = smp_valid && (m_nfull == 2);
      m_freed = 0;
      if (sched.size() == 0) begin
        if (m_nfull > 0) begin
          if (ch_req == '0) m_freed = 1;
          else begin
            m_blk = full_q[0];
            for (int k = 0; k < NUM_CH; k++) begin
              m_c = (m_rr + k) % NUM_CH;
              if (ch_req[m_c]) begin
                m_s = '{1'b1, m_c, 3'd0, 1'b0, 1'b0};
                sched.push_back(m_s);
                for (int j = 0; j < BLK_LEN; j++) begin
                  m_s = '{1'b0, m_c, m_blk[3*j +: 3], (j == 0), (j == BLK_LEN-1)};
                  sched.push_back(m_s);
                end
              end
            end
          end
        end
      end else begin
        m_head = sched[0];
        if (m_head.gap) void'(sched.pop_front());
        else if (out_ready) begin
          void'(sched.pop_front());
          if (m_head.last) begin
            m_rr = (m_head.ch + 1) % NUM_CH;
            if (sched.size() == 0) m_freed = 1;
          end
        end
      end
      if (m_freed) void'(full_q.pop_front());
      if (smp_valid && !m_drop) begin
        m_fill[3*m_fillcnt +: 3] = smp_data;
        m_fillcnt++;
        if (m_fillcnt == BLK_LEN) begin
          full_q.push_back(m_fill);
          m_fillcnt = 0;
        end
      end
      if (m_drop) m_flag = 1;
      else if (ovf_clr) m_flag = 0;
`ifdef SCHED_OVF_CNT_EN
      if (ovf_clr) m_cnt = m_drop ? 1 : 0;
      else if (m_drop && m_cnt < 65535) m_cnt++;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] exp_v, act_v;
  logic [15:0] exp_cnt;
  always @(negedge clk) begin
    if (chk_en) begin
`ifdef SCHED_OVF_CNT_EN
      exp_cnt = 16'(m_cnt);
`else
      exp_cnt = 16'd0;
`endif
      if (sched.size() > 0 && !sched[0].gap)
        exp_v = {6'd0, 1'b1, sched[0].data, CH_W'(sched[0].ch), sched[0].first,
                 sched[0].last, 1'b1, m_flag, exp_cnt};
      else
        exp_v = {6'd0, 1'b0, 3'd0, CH_W'(0), 1'b0, 1'b0, (sched.size() > 0),
                 m_flag, exp_cnt};
      act_v = {6'd0, out_valid, out_data, out_ch, out_first, out_last, busy,
               ovf_flag, ovf_count};
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- accepted-beat monitor ----------------
  typedef struct { int cyc; int ch; int data; bit first; bit last; } beat_t;
  beat_t mon[$];
  beat_t mb;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready) begin
      mb = '{cyc, int'(out_ch), int'(out_data), out_first, out_last};
      mon.push_back(mb);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return {v[1:0], 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; smp_valid = 0; ovf_clr = 0;
    tick(); tick();
    reset = 1'b0;
    mon.delete();
  endtask

  task automatic feed_block(input int base);
    for (int i = 0; i < BLK_LEN; i++) begin
      smp_valid = 1'b1; smp_data = pat(base + i);
      tick();
    end
    smp_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int b;
    b = 0;
    while (mon.size() < n && b < 500) begin tick(); b++; end
    check("wait_beats_count", (mon.size() >= n) ? n : mon.size(), n);
  endtask

  int full_cyc;
  int ord[3] = '{0, 1, 3};

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: single channel, latency, order, framing
    do_reset();
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    ch_req = 4'b0001; out_ready = 1;
    feed_block(0);
    full_cyc = cyc;
    wait_beats(16);
    repeat (3) tick();
    check("t1_latency", mon[0].cyc - full_cyc, 2);
    for (int i = 0; i < 16; i++)
      check($sformatf("t1_beat%0d", i),
            {mon[i].ch, mon[i].data, 2'(mon[i].first), 2'(mon[i].last)},
            {0, int'(pat(i)), 2'(i == 0), 2'(i == 15)});
    check("t1_busy_after", busy, 0);

    // 2: three requesters, round robin across two blocks
    do_reset();
    ch_req = 4'b1011; out_ready = 1;
    feed_block(0);
    feed_block(16);
    wait_beats(96);
    for (int k = 0; k < 96; k += 8)
      check($sformatf("t2_ch_beat%0d", k), mon[k].ch, ord[(k/16) % 3]);
    check("t2_gap_01", mon[16].cyc - mon[15].cyc, 2);
    check("t2_gap_13", mon[32].cyc - mon[31].cyc, 2);
    check("t2_blk2_data", mon[50].data, int'(pat(2)));

    // 3: back-pressure mid-block
    do_reset();
    ch_req = 4'b0001; out_ready = 1;
    feed_block(0);
    wait_beats(6);
    out_ready = 0;
    repeat (5) tick();
    out_ready = 1;
    wait_beats(16);
    repeat (3) tick();
    check("t3_beats", mon.size(), 16);
    for (int i = 0; i < 16; i += 3)
      check($sformatf("t3_data%0d", i), mon[i].data, int'(pat(i)));

    // 4: overflow with all channels requesting
    do_reset();
    ch_req = 4'b1111; out_ready = 1;
    for (int i = 0; i < 85; i++) begin
      smp_valid = 1; smp_data = pat(i);
      tick();
      if (i == 31) check("t4_flag_before", ovf_flag, 0);
      if (i == 32) check("t4_flag_first_drop", ovf_flag, 1);
    end
    smp_valid = 0;
    check("t4_flag", ovf_flag, 1);
`ifdef SCHED_OVF_CNT_EN
    check("t4_count", ovf_count, 53);
`else
    check("t4_count", ovf_count, 0);
`endif
    ovf_clr = 1; tick(); ovf_clr = 0;
    check("t4_flag_clr", ovf_flag, 0);
    check("t4_count_clr", ovf_count, 0);
    repeat (90) tick();

    // 5: no requester: block discarded
    do_reset();
    ch_req = 4'b0000; out_ready = 1;
    feed_block(0);
    repeat (10) tick();
    check("t5_no_beats", mon.size(), 0);
    check("t5_no_ovf", ovf_flag, 0);
    ch_req = 4'b0100;
    feed_block(3);
    wait_beats(16);
    check("t5_next_ch", mon[0].ch, 2);

    // 6: reset during beat 7
    do_reset();
    ch_req = 4'b0001; out_ready = 1;
    feed_block(0);
    wait_beats(7);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid_rst", out_valid, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_last_rst", out_last, 0);
    tick();
    reset = 1'b0;
    mon.delete();
    feed_block(2);
    wait_beats(16);
    check("t6_first_data", mon[0].data, int'(pat(2)));
    check("t6_first_flag", mon[0].first, 1);

    // 7: randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      smp_valid = ($urandom_range(0, 3) != 0);
      smp_data  = {$urandom_range(0, 3) == 0 ? 2'b00 : 2'($urandom), 1'b1};
      if ($urandom_range(0, 15) == 0) ch_req = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 63) == 0);
      tick();
    end
    smp_valid = 0; ovf_clr = 0; out_ready = 1;
    repeat (300) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
